// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive control front-end.
// FSM state encoding, legal prescale values, reset prescale and watchdog multiplier.
package uart_rx_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8     = 6'd8;
    localparam logic [5:0] PRESCALE_16    = 6'd16;
    localparam logic [5:0] PRESCALE_32    = 6'd32;
    localparam logic [5:0] RST_PRESCALE   = PRESCALE_8;
    localparam int         TIMEOUT_MULT   = 12;

    function automatic logic prescale_legal(input logic [5:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous receive FIFO: 1-cycle push-to-head latency, head shown as 0 while empty.
// Push while full without a same-cycle pop is dropped and flagged on drop_o.
module uart_rx_ctrl_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_dat_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: frame FSM, between-frame config apply, byte FIFO, error counters.
// Optional watchdog under UART_RX_CTRL_TIMEOUT_EN adds a timeout pulse output.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cfg_wr,
    input  logic [5:0]               cfg_prescale,
    input  logic                     cfg_par_en,
    input  logic                     cfg_par_typ,
    output logic [5:0]               prescale,
    output logic                     PAR_EN,
    output logic                     PAR_TYP,
    output logic                     cfg_pending,
    output logic                     cfg_err,
    input  logic                     RX_IN,
    input  logic [DATA_WIDTH-1:0]    P_DATA,
    input  logic                     data_valid,
    input  logic                     par_err,
    input  logic                     stp_err,
    input  logic                     strt_glitch,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     rd_ready,
    output logic                     overflow,
    input  logic                     clr,
`ifdef UART_RX_CTRL_TIMEOUT_EN
    output logic                     timeout,
`endif
    output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] glitch_cnt,
    output logic                     busy
);
    rx_state_e  state_q;
    logic       rx_prev_q;
    logic [5:0] sh_prescale_q;
    logic       sh_par_en_q, sh_par_typ_q;
    logic       fall, frame_end, cfg_ok, fifo_empty, fifo_full, fifo_drop;

    assign fall      = rx_prev_q && !RX_IN;
    assign frame_end = data_valid || par_err || stp_err || strt_glitch;
    assign cfg_ok    = prescale_legal(cfg_prescale);
    assign busy      = (state_q == ACTIVE);

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [9:0] wdog_q;
    logic [9:0] wdog_limit;
    assign wdog_limit = 10'(TIMEOUT_MULT) * {4'd0, prescale};
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            rx_prev_q     <= 1'b1;
            sh_prescale_q <= RST_PRESCALE;
            sh_par_en_q   <= 1'b0;
            sh_par_typ_q  <= 1'b0;
            prescale      <= RST_PRESCALE;
            PAR_EN        <= 1'b0;
            PAR_TYP       <= 1'b0;
            cfg_pending   <= 1'b0;
            cfg_err       <= 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            wdog_q        <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            rx_prev_q <= RX_IN;
            cfg_err   <= cfg_wr && !cfg_ok;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            timeout   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= ACTIVE;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                default: begin
                    if (frame_end) begin
                        state_q <= IDLE;
`ifdef UART_RX_CTRL_TIMEOUT_EN
                    end else if (wdog_q == wdog_limit) begin
                        state_q <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wdog_q  <= wdog_q + 1'b1;
`endif
                    end
                end
            endcase
            // Apply only while idle and not about to start a frame; a write in the
            // same cycle still lands in the shadow and stays pending.
            if (cfg_pending && state_q == IDLE && !fall) begin
                prescale    <= sh_prescale_q;
                PAR_EN      <= sh_par_en_q;
                PAR_TYP     <= sh_par_typ_q;
                cfg_pending <= 1'b0;
            end
            if (cfg_wr && cfg_ok) begin
                sh_prescale_q <= cfg_prescale;
                sh_par_en_q   <= cfg_par_en;
                sh_par_typ_q  <= cfg_par_typ;
                cfg_pending   <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            glitch_cnt  <= '0;
            overflow    <= 1'b0;
        end else if (clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            glitch_cnt  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (par_err && !(&par_err_cnt))     par_err_cnt <= par_err_cnt + 1'b1;
            if (stp_err && !(&stp_err_cnt))     stp_err_cnt <= stp_err_cnt + 1'b1;
            if (strt_glitch && !(&glitch_cnt))  glitch_cnt  <= glitch_cnt + 1'b1;
            if (fifo_drop)                      overflow    <= 1'b1;
        end
    end

    uart_rx_ctrl_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RST),
        .push_i     (data_valid),
        .push_dat_i (P_DATA),
        .pop_i      (rd_ready),
        .head_dat_o (rd_data),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (fifo_drop)
    );

    assign rd_valid = !fifo_empty;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed config/FSM cases plus a byte scoreboard.
module tb_uart_rx_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [5:0] cfg_prescale = 6'd0;
    logic       cfg_par_en = 1'b0, cfg_par_typ = 1'b0;
    logic [5:0] prescale;
    logic       PAR_EN, PAR_TYP, cfg_pending, cfg_err;
    logic       RX_IN = 1'b1;
    logic [7:0] P_DATA = 8'd0;
    logic       data_valid = 1'b0, par_err = 1'b0, stp_err = 1'b0, strt_glitch = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready = 1'b0;
    logic       overflow;
    logic       clr = 1'b0;
    logic [7:0] par_err_cnt, stp_err_cnt, glitch_cnt;
    logic       busy;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic       timeout;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ERR_CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
        .cfg_par_typ(cfg_par_typ), .prescale(prescale), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .RX_IN(RX_IN), .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err),
        .stp_err(stp_err), .strt_glitch(strt_glitch), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_ready(rd_ready), .overflow(overflow), .clr(clr),
`ifdef UART_RX_CTRL_TIMEOUT_EN
        .timeout(timeout),
`endif
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt),
        .glitch_cnt(glitch_cnt), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drives one byte; the model keeps it unless the FIFO is full with no same-cycle pop.
    task automatic push_byte(input logic [7:0] b, input logic pop);
        data_valid = 1'b1;
        P_DATA     = b;
        rd_ready   = pop;
        if (pop && rd_valid) begin
            chk("pop_same_cycle", rd_data, exp_q.pop_front());
        end
        if (exp_q.size() < 4) exp_q.push_back(b);
        step();
        data_valid = 1'b0;
        rd_ready   = 1'b0;
    endtask

    task automatic drain();
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!rd_valid) break;
            if (exp_q.size() == 0) begin
                chk("drain_extra", {24'd0, rd_data}, 32'hFFFF_FFFF);
            end else begin
                chk("drain_data", rd_data, exp_q.pop_front());
            end
            step();
        end
        rd_ready = 1'b0;
        chk("drain_left", exp_q.size(), 0);
        chk("drain_empty", rd_valid, 0);
    endtask

    initial begin
        #12;
        RST = 1'b1;
        step();
        chk("rst_prescale", prescale, 8);
        chk("rst_par_en", PAR_EN, 0);
        chk("rst_par_typ", PAR_TYP, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cnts", {par_err_cnt, stp_err_cnt, glitch_cnt}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", cfg_pending, 0);
        chk("rst_overflow", overflow, 0);

        // Illegal prescale is rejected.
        cfg_wr = 1'b1; cfg_prescale = 6'd12; cfg_par_en = 1'b1;
        step();
        cfg_wr = 1'b0;
        chk("ill_cfg_err", cfg_err, 1);
        chk("ill_pending", cfg_pending, 0);
        chk("ill_prescale", prescale, 8);
        step();
        chk("ill_cfg_err_once", cfg_err, 0);
        chk("ill_par_en", PAR_EN, 0);

        // Legal write while idle.
        cfg_wr = 1'b1; cfg_prescale = 6'd16; cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        step();
        cfg_wr = 1'b0;
        chk("idle_pending", cfg_pending, 1);
        chk("idle_not_yet", prescale, 8);
        step();
        chk("idle_prescale", prescale, 16);
        chk("idle_par_en", PAR_EN, 1);
        chk("idle_par_typ", PAR_TYP, 1);
        chk("idle_pending_clr", cfg_pending, 0);

        // Write during a frame is held until the frame ends.
        RX_IN = 1'b0;
        step();
        chk("act_busy", busy, 1);
        cfg_wr = 1'b1; cfg_prescale = 6'd32; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        step();
        cfg_wr = 1'b0;
        chk("act_pending", cfg_pending, 1);
        step(); step();
        chk("act_hold_prescale", prescale, 16);
        chk("act_hold_par_en", PAR_EN, 1);
        push_byte(8'h5A, 1'b0);
        chk("end_idle", busy, 0);
        chk("end_still_pending", cfg_pending, 1);
        chk("end_prescale_hold", prescale, 16);
        chk("lat_rd_valid", rd_valid, 1);
        chk("lat_rd_data", rd_data, 8'h5A);
        step();
        chk("end_applied_prescale", prescale, 32);
        chk("end_applied_par_en", PAR_EN, 0);
        chk("end_pending_clr", cfg_pending, 0);
        RX_IN = 1'b1;
        drain();

        // Fill past depth with no reads.
        push_byte(8'hA5, 1'b0);
        push_byte(8'h3C, 1'b0);
        push_byte(8'hFF, 1'b0);
        push_byte(8'h01, 1'b0);
        chk("full_no_ovf", overflow, 0);
        push_byte(8'h77, 1'b0);
        chk("ovf_set", overflow, 1);
        drain();
        chk("ovf_sticky", overflow, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Full FIFO with a same-cycle pop accepts the push.
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        push_byte(8'h44, 1'b0);
        push_byte(8'h99, 1'b1);
        chk("full_pop_no_ovf", overflow, 0);
        drain();

        // Saturation and simultaneous pulses.
        for (int i = 0; i < 300; i++) begin
            par_err = 1'b1;
            step();
        end
        par_err = 1'b0;
        chk("par_sat", par_err_cnt, 255);
        stp_err = 1'b1; strt_glitch = 1'b1;
        step();
        stp_err = 1'b0; strt_glitch = 1'b0;
        chk("stp_one", stp_err_cnt, 1);
        chk("glitch_one", glitch_cnt, 1);
        chk("par_hold", par_err_cnt, 255);
        clr = 1'b1; stp_err = 1'b1;
        step();
        clr = 1'b0; stp_err = 1'b0;
        chk("clr_prio_stp", stp_err_cnt, 0);
        chk("clr_par", par_err_cnt, 0);
        chk("clr_glitch", glitch_cnt, 0);

        // Asynchronous reset in the middle of a frame.
        RX_IN = 1'b0;
        step();
        chk("mid_busy", busy, 1);
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_prescale", prescale, 8);
        RX_IN = 1'b1;
        #10;
        RST = 1'b1;
        step();
        chk("post_rst_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control and buffering front-end for the UART receiver datapath. It owns the receiver configuration (prescale, parity enable, parity type) and applies updates only between frames. It tracks frame activity with a small FSM, and captures received bytes into a FIFO with a valid/ready read port. It also keeps saturating error counters for parity, stop and start-glitch events. It sits between the host/register side and the receive core, sharing the CLK_RX domain.

Parameters:
DATA_WIDTH, 8, width of received data / P_DATA
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2
ERR_CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK  in  1  receiver clock (CLK_RX domain)
RST  in  1  asynchronous active-low reset
cfg_wr  in  1  config write strobe (1 cycle)
cfg_prescale  in  6  requested prescale; legal values are 8, 16, 32
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
prescale  out  6  applied prescale to the receive core
PAR_EN  out  1  applied parity enable
PAR_TYP  out  1  applied parity type
cfg_pending  out  1  a legal config is waiting for idle
cfg_err  out  1  1-cycle pulse: illegal prescale was written
RX_IN  in  1  serial line, already synchronous to CLK
P_DATA  in  DATA_WIDTH  deserialized byte from the core
data_valid  in  1  core pulse: frame good, P_DATA valid
par_err  in  1  core parity error pulse
stp_err  in  1  core stop error pulse
strt_glitch  in  1  core start glitch pulse
rd_valid  out  1  FIFO not empty
rd_data  out  DATA_WIDTH  FIFO head
rd_ready  in  1  consumer accepts head
overflow  out  1  sticky: a byte was dropped while FIFO full
clr  in  1  clears overflow and all error counters
par_err_cnt  out  ERR_CNT_WIDTH  saturating parity error count
stp_err_cnt  out  ERR_CNT_WIDTH  saturating stop error count
glitch_cnt  out  ERR_CNT_WIDTH  saturating start-glitch count
busy  out  1  FSM in ACTIVE

Behaviour:
- Reset (RST low, async) values:
  - prescale = 8, PAR_EN = 0, PAR_TYP = 0.
  - cfg_pending = 0, cfg_err = 0, overflow = 0, all counters = 0, busy = 0.
  - FIFO empty, so rd_valid = 0 and rd_data = 0.
  - FSM in IDLE, previous-RX_IN register = 1.
- FSM states: IDLE, ACTIVE.
  - IDLE -> ACTIVE on an RX_IN falling edge (previous sample 1, current sample 0).
  - ACTIVE -> IDLE on any of data_valid, par_err, stp_err, strt_glitch (frame-end event).
  - busy = (state == ACTIVE).
- Configuration:
  - cfg_wr with cfg_prescale not in {8, 16, 32}: write ignored, cfg_err pulses for 1 cycle, existing shadow unchanged.
  - Legal cfg_wr: loads the shadow registers and sets cfg_pending.
  - The shadow is copied to the outputs on the first cycle with state == IDLE and no falling edge on RX_IN in that cycle; cfg_pending clears in the same cycle.
  - If cfg_wr arrives while IDLE, the config applies on the next cycle.
  - A second cfg_wr while pending overwrites the shadow (last write wins).
  - Applied outputs never change while ACTIVE.
- FIFO:
  - Push on data_valid with P_DATA.
  - Pop on rd_valid && rd_ready.
  - Latency: data_valid in cycle N into an empty FIFO gives rd_valid = 1 and rd_data = P_DATA in cycle N+1.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare.
  - Push while full and no pop: byte dropped, overflow set (sticky).
  - Push while full with a pop in the same cycle: both happen, no overflow.
  - Pop while empty: ignored.
- Counters:
  - Each of par_err, stp_err, strt_glitch increments its own counter by 1.
  - Counters saturate at all-ones and never wrap.
  - Simultaneous error pulses each increment their own counter in the same cycle.
  - A pulse arriving in IDLE still counts.
- clr:
  - Zeroes the counters and overflow.
  - clr has priority over an increment or overflow set in the same cycle.
  - FIFO contents and config are unaffected.
- Reset mid-frame: everything returns to reset values immediately; no partial state survives.

Optional Feature:
UART_RX_CTRL_TIMEOUT_EN
- Defined:
  - A 10-bit watchdog counts cycles in ACTIVE.
  - When it reaches 12*prescale, the FSM forces ACTIVE -> IDLE and pulses output timeout (1 bit, 1 cycle).
  - The watchdog clears on every entry to ACTIVE.
- Undefined:
  - No watchdog and no timeout port.
  - ACTIVE exits only on frame-end events.

Decomposition:
- Package uart_rx_ctrl_pkg holds:
  - typedef enum of the FSM states (IDLE, ACTIVE);
  - localparams for the legal prescale values (8, 16, 32);
  - the reset prescale (8);
  - the timeout multiplier (12).
- One sub-module, uart_rx_ctrl_fifo: synchronous FIFO with push/pop, full/empty and drop indication.
- The FSM, config logic and counters stay in the top.

Test Plan:
- Reset then idle: prescale = 8, PAR_EN = 0, rd_valid = 0, all counters 0.
- cfg_wr prescale = 16, PAR_EN = 1, PAR_TYP = 1 while IDLE -> outputs take 16/1/1 on the next cycle, cfg_pending pulses for 1 cycle.
- cfg_wr while ACTIVE -> outputs unchanged and cfg_pending = 1 until data_valid; new values are applied 1 cycle after the FSM returns to IDLE.
- cfg_wr with prescale = 12 -> cfg_err pulses once, prescale stays 8, cfg_pending = 0.
- Push bytes 0xA5, 0x3C, 0xFF, 0x01, 0x77 with rd_ready = 0 (FIFO_DEPTH = 4):
  - rd_data sequence is 0xA5, 0x3C, 0xFF, 0x01;
  - overflow = 1 after 0x77;
  - clr sets overflow back to 0.
- 300 par_err pulses with ERR_CNT_WIDTH = 8 -> par_err_cnt = 255. Simultaneous stp_err and strt_glitch pulses -> each of their counters increments by 1.
